mpu_mul_seq: RTL and testbench

MPU_MUL_SEQ -- requirements
Module: mpu_mul_seq

---
 rtl/mpu_pkg.sv | 20 ++
 rtl/mpu_row_mac.sv | 49 ++++
 rtl/mpu_mul_seq.sv | 126 ++++++++++++
 tb/tb_mpu_mul_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared constants, FSM state type and flattened-matrix offset helper for the
// sequential matrix multiplier.
package mpu_pkg;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 2*ELEM_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mpu_state_t;

    // Bit offset of element (r,c) in a row-major flattened dim x dim matrix.
    function automatic int elem_off(input int r, input int c, input int dim, input int elem_w);
        return elem_w * (c + dim * r);
    endfunction

endpackage

// File: rtl/mpu_row_mac.sv
// Combinational row multiply: one A row times full B matrix -> one result row.
// MPU_SATURATE_EN selects clamping with a per-row clamp flag; otherwise results wrap.
module mpu_row_mac
    import mpu_pkg::*;
#(
    parameter int DIM    = mpu_pkg::DIM,
    parameter int ELEM_W = mpu_pkg::ELEM_W
) (
    input  logic [ELEM_W*DIM-1:0]     a_row,
    input  logic [ELEM_W*DIM*DIM-1:0] mat_b,
    output logic [ELEM_W*DIM-1:0]     row_out,
    output logic                      clamp
);

    localparam int SUM_W = 2*ELEM_W + 3;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (ELEM_W-1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [2*ELEM_W-1:0] prod;
    logic signed [SUM_W-1:0]    acc [DIM];

    always_comb begin
        row_out = '0;
        clamp   = 1'b0;
        prod    = '0;
        for (int c = 0; c < DIM; c++) begin
            acc[c] = '0;
            for (int k = 0; k < DIM; k++) begin
                prod   = $signed(a_row[elem_off(0, k, DIM, ELEM_W) +: ELEM_W])
                       * $signed(mat_b[elem_off(k, c, DIM, ELEM_W) +: ELEM_W]);
                acc[c] = acc[c] + SUM_W'(prod);
            end
`ifdef MPU_SATURATE_EN
            if (acc[c] > SAT_HI) begin
                row_out[c*ELEM_W +: ELEM_W] = SAT_HI[ELEM_W-1:0];
                clamp = 1'b1;
            end else if (acc[c] < SAT_LO) begin
                row_out[c*ELEM_W +: ELEM_W] = SAT_LO[ELEM_W-1:0];
                clamp = 1'b1;
            end else begin
                row_out[c*ELEM_W +: ELEM_W] = ELEM_W'(acc[c]);
            end
`else
            row_out[c*ELEM_W +: ELEM_W] = ELEM_W'(acc[c]);
`endif
        end
    end

endmodule

// File: rtl/mpu_mul_seq.sv
// Sequential signed NxN matrix multiplier, one result row per cycle.
// Define MPU_SATURATE_EN for saturating results and a live overflow flag.
//
// state   | meaning
// IDLE    | waiting for start; invalid size pulses error
// RUN     | writing result row row_q each cycle
// DONE    | one-cycle completion, result held
module mpu_mul_seq
    import mpu_pkg::*;
#(
    parameter int DIM    = mpu_pkg::DIM,
    parameter int ELEM_W = mpu_pkg::ELEM_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                size,
    input  logic [ELEM_W*DIM*DIM-1:0] matrix_a,
    input  logic [ELEM_W*DIM*DIM-1:0] matrix_b,
    output logic [ELEM_W*DIM*DIM-1:0] result,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      overflow
);

    localparam int RW = ELEM_W*DIM;
    localparam int MW = RW*DIM;

    mpu_state_t state, state_nxt;

    logic [7:0]    row_q, size_q;
    logic [MW-1:0] a_q, b_q, a_msk, b_msk, result_q;
    logic [RW-1:0] a_row, row_out;
    logic          row_clamp, ovf_q, error_q;
    logic          size_ok, accept, last_row;

    assign size_ok  = (size != 8'd0) && (int'(size) <= DIM);
    assign accept   = (state == ST_IDLE) && start && size_ok;
    assign last_row = (row_q == size_q - 8'd1);

    // Out-of-range rows and columns are zeroed at capture so they never contribute.
    always_comb begin
        a_msk = '0;
        b_msk = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (r < int'(size) && c < int'(size)) begin
                    a_msk[elem_off(r, c, DIM, ELEM_W) +: ELEM_W] = matrix_a[elem_off(r, c, DIM, ELEM_W) +: ELEM_W];
                    b_msk[elem_off(r, c, DIM, ELEM_W) +: ELEM_W] = matrix_b[elem_off(r, c, DIM, ELEM_W) +: ELEM_W];
                end
            end
        end
    end

    always_comb begin
        a_row = '0;
        for (int r = 0; r < DIM; r++) begin
            if (r == int'(row_q)) a_row = a_q[r*RW +: RW];
        end
    end

    mpu_row_mac #(.DIM(DIM), .ELEM_W(ELEM_W)) u_row_mac (
        .a_row   (a_row),
        .mat_b   (b_q),
        .row_out (row_out),
        .clamp   (row_clamp)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = ST_RUN;
            ST_RUN:  if (last_row) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            size_q   <= '0;
            row_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            error_q <= (state == ST_IDLE) && start && !size_ok;
            if (accept) begin
                a_q      <= a_msk;
                b_q      <= b_msk;
                size_q   <= size;
                row_q    <= '0;
                result_q <= '0;
                ovf_q    <= 1'b0;
            end else if (state == ST_RUN) begin
                for (int r = 0; r < DIM; r++) begin
                    if (r == int'(row_q)) result_q[r*RW +: RW] <= row_out;
                end
                ovf_q <= ovf_q | row_clamp;
                row_q <= row_q + 8'd1;
            end
        end
    end

    assign result = result_q;
    assign error  = error_q;
`ifdef MPU_SATURATE_EN
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0 & ovf_q;
`endif

endmodule

// File: tb/tb_mpu_mul_seq.sv
// Scoreboard bench for mpu_mul_seq: stimulus pushes expected products, a
// negedge monitor pops and compares on every done pulse.
module tb_mpu_mul_seq;

    localparam int DIM = 5;
    localparam int EW  = 8;
    localparam int MW  = EW*DIM*DIM;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [7:0]    size;
    logic [MW-1:0] matrix_a, matrix_b, result;
    logic          busy, done, error, overflow;

    mpu_mul_seq #(.DIM(DIM), .ELEM_W(EW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .size     (size),
        .matrix_a (matrix_a),
        .matrix_b (matrix_b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [MW-1:0] res;
        logic          ovf;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    function automatic int off(input int r, input int c);
        return EW * (c + DIM * r);
    endfunction

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c, input int v);
        m[off(r, c) +: EW] = EW'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] fill_n(input int v, input int n);
        logic [MW-1:0] m = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                m = put(m, r, c, v);
        return m;
    endfunction

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: actual=done required=no_done");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_ovf"}, MW'(overflow), MW'(mon_e.ovf));
            end
        end
    end

    task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b, input int n,
                         input bit push, input string name, input logic [MW-1:0] res, input logic ovf);
        exp_t e;
        @(posedge clock);
        #1;
        matrix_a = a;
        matrix_b = b;
        size     = 8'(n);
        start    = 1'b1;
        if (push) begin
            e.res = res; e.ovf = ovf; e.name = name;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        int k  = 0;
        int bc = 0;
        bit found = 0;
        while (!found && k < 30) begin
            @(negedge clock);
            k++;
            if (done === 1'b1) found = 1;
            else if (busy === 1'b1) bc++;
        end
        if (!found) k = 99;
        chk({name, "_latency"}, MW'(k), MW'(n + 1));
        chk({name, "_busy_cycles"}, MW'(bc), MW'(n));
    endtask

    logic [MW-1:0] a_v, b_v, e_v, prev;
    int            d0;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        size     = 8'd5;
        matrix_a = fill_n(1, 5);
        matrix_b = fill_n(1, 5);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("rst_busy", MW'(busy), '0);
        chk("rst_done", MW'(done), '0);
        chk("rst_error", MW'(error), '0);
        chk("rst_ovf", MW'(overflow), '0);
        chk("rst_result", result, '0);

        // identity x (1..25) -> B
        a_v = '0; b_v = '0;
        for (int r = 0; r < 5; r++) begin
            a_v = put(a_v, r, r, 1);
            for (int c = 0; c < 5; c++) b_v = put(b_v, r, c, r*5 + c + 1);
        end
        issue(a_v, b_v, 5, 1, "ident", b_v, 1'b0);
        wait_done(5, "ident");

        // all ones, N=3
        issue(fill_n(1, 5), fill_n(1, 5), 3, 1, "ones3", fill_n(3, 3), 1'b0);
        wait_done(3, "ones3");
        prev = fill_n(3, 3);

        // invalid sizes
        issue(fill_n(7, 5), fill_n(7, 5), 0, 0, "", '0, 1'b0);
        @(negedge clock);
        chk("size0_error", MW'(error), MW'(1));
        chk("size0_busy", MW'(busy), '0);
        @(negedge clock);
        chk("size0_error_drop", MW'(error), '0);
        issue(fill_n(7, 5), fill_n(7, 5), 6, 0, "", '0, 1'b0);
        @(negedge clock);
        chk("size6_error", MW'(error), MW'(1));
        chk("size6_busy", MW'(busy), '0);
        @(negedge clock);
        chk("size6_error_drop", MW'(error), '0);
        chk("size_bad_result_held", result, prev);

        // all 127
`ifdef MPU_SATURATE_EN
        e_v = fill_n(127, 5);
        issue(fill_n(127, 5), fill_n(127, 5), 5, 1, "big", e_v, 1'b1);
        wait_done(5, "big");
        @(negedge clock);
        chk("big_ovf_sticky", MW'(overflow), MW'(1));
`else
        e_v = fill_n(5, 5);
        issue(fill_n(127, 5), fill_n(127, 5), 5, 1, "big", e_v, 1'b0);
        wait_done(5, "big");
        @(negedge clock);
        chk("big_ovf_sticky", MW'(overflow), '0);
`endif
        chk("big_result_held", result, e_v);

        // start during RUN must be ignored; inputs change mid-run
        d0 = done_cnt;
        issue(fill_n(1, 5), fill_n(1, 5), 5, 1, "norestart", fill_n(5, 5), 1'b0);
        @(negedge clock);
        matrix_a = fill_n(-3, 5);
        matrix_b = fill_n(2, 5);
        size     = 8'd4;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 30 && done !== 1'b1; k++) @(negedge clock);
        repeat (4) @(negedge clock);
        chk("norestart_done_count", MW'(done_cnt - d0), MW'(1));

        // reset mid-run at row 2
        issue(fill_n(2, 5), fill_n(2, 5), 5, 0, "", '0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", MW'(busy), '0);
        chk("midrst_done", MW'(done), '0);
        chk("midrst_result", result, '0);

        // signed N=2 with out-of-range garbage that must be masked
        a_v = '0; b_v = '0;
        a_v = put(a_v, 0, 0, 1);  a_v = put(a_v, 0, 1, -2);
        a_v = put(a_v, 1, 0, 3);  a_v = put(a_v, 1, 1, 4);
        a_v = put(a_v, 0, 2, 9);  a_v = put(a_v, 3, 3, 9);
        b_v = put(b_v, 0, 0, 5);  b_v = put(b_v, 0, 1, 6);
        b_v = put(b_v, 1, 0, -7); b_v = put(b_v, 1, 1, 8);
        b_v = put(b_v, 2, 0, 9);  b_v = put(b_v, 1, 4, 9);
        e_v = '0;
        e_v = put(e_v, 0, 0, 19);  e_v = put(e_v, 0, 1, -10);
        e_v = put(e_v, 1, 0, -13); e_v = put(e_v, 1, 1, 50);
        issue(a_v, b_v, 2, 1, "signed2", e_v, 1'b0);
        wait_done(2, "signed2");

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", MW'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
